vc_input_unit: RTL and testbench

Parametrised router input unit: the next generation of the router's per-port input logic. It buffers incoming flits in VC_NUM per-virtual-channel FIFOs and runs a per-VC state machine that resolves each packet's output port from a writable routing table. It arbitrates round-robin among ready VCs onto a registered valid/ready output toward the switch, and returns one credit upstream per flit dequeued.

---
 rtl/vc_input_unit_if.sv | 32 +++
 rtl/vc_input_unit.sv | 148 ++++++++++++++
 tb/tb_vc_input_unit.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vc_input_unit_if.sv
// vc_input_unit_if: flit-in / credit-out / switch-side handshake bundle for vc_input_unit
//   flit_in_valid, flit_in, flit_in_vc   : upstream flit write into a VC buffer
//   credit_out_valid, credit_out_vc      : one-cycle credit pulse back upstream
//   out_valid, out_ready                 : registered valid/ready toward the switch
//   flit_out, out_port, out_vc           : flit, resolved output port and VC on the switch side
//   modport slave  : the input unit itself
//   modport master : the upstream router / switch side driving and consuming it
interface vc_input_unit_if #(
  parameter int FLIT_W = 32,
  parameter int VC_NUM = 4,
  parameter int PORT_W = 3,
  parameter int VC_W = (VC_NUM > 1) ? $clog2(VC_NUM) : 1
);
  logic flit_in_valid;
  logic [FLIT_W-1:0] flit_in;
  logic [VC_W-1:0] flit_in_vc;
  logic credit_out_valid;
  logic [VC_W-1:0] credit_out_vc;
  logic out_valid;
  logic out_ready;
  logic [FLIT_W-1:0] flit_out;
  logic [PORT_W-1:0] out_port;
  logic [VC_W-1:0] out_vc;
  modport slave (
    input flit_in_valid, flit_in, flit_in_vc, out_ready,
    output credit_out_valid, credit_out_vc, out_valid, flit_out, out_port, out_vc
  );
  modport master (
    output flit_in_valid, flit_in, flit_in_vc, out_ready,
    input credit_out_valid, credit_out_vc, out_valid, flit_out, out_port, out_vc
  );
endinterface

// File: rtl/vc_input_unit.sv
// vc_input_unit: router input port with per-VC FIFOs, per-VC route FSM, round-robin switch output, credit return
//   clk                      : rising-edge clock
//   reset                    : asynchronous active-low reset
//   bus (slave)              : flit input, credit output, switch-side valid/ready output
//   tbl_we/tbl_addr/tbl_data : routing-table write port (dest -> output port)
//   err_overflow             : sticky, a flit arrived for a full VC
//   err_protocol             : sticky, a body/tail flit reached the front of an IDLE VC
// Optional feature: define NOC_ROUTE_BYPASS_EN to drop the ROUTE state and look the table up
// combinationally in IDLE, saving one cycle of head latency.
module vc_input_unit #(
  parameter int FLIT_W = 32,
  parameter int VC_NUM = 4,
  parameter int BUF_DEPTH = 4,
  parameter int DEST_W = 4,
  parameter int PORT_W = 3,
  localparam int VC_W = (VC_NUM > 1) ? $clog2(VC_NUM) : 1
) (
  input  logic clk,
  input  logic reset,
  vc_input_unit_if.slave bus,
  input  logic tbl_we,
  input  logic [DEST_W-1:0] tbl_addr,
  input  logic [PORT_W-1:0] tbl_data,
  output logic err_overflow,
  output logic err_protocol
);
  localparam int AW = $clog2(BUF_DEPTH);
  typedef enum logic [1:0] {IDLE, ROUTE, ACTIVE} st_t;
`ifdef NOC_ROUTE_BYPASS_EN
  localparam st_t FIRST = ACTIVE;
`else
  localparam st_t FIRST = ROUTE;
`endif
  logic [FLIT_W-1:0] mem [VC_NUM][BUF_DEPTH];
  logic [AW:0] wr_ptr [VC_NUM];
  logic [AW:0] rd_ptr [VC_NUM];
  logic [PORT_W-1:0] tbl [2**DEST_W];
  logic [PORT_W-1:0] vc_port [VC_NUM];
  logic [PORT_W-1:0] lookup [VC_NUM];
  logic [FLIT_W-1:0] front [VC_NUM];
  st_t state [VC_NUM];
  st_t state_nxt [VC_NUM];
  logic [VC_NUM-1:0] nonempty, full, head, tail, eligible, discard, route_en, pop, push, drop;
  logic [VC_W-1:0] rr_ptr, gnt, cred_vc;
  logic found, load, cred_pend;
  // Front-of-FIFO decode; pointers carry one extra wrap bit so full and empty differ
  always_comb begin
    for (int v = 0; v < VC_NUM; v++) begin
      front[v] = mem[v][rd_ptr[v][AW-1:0]];
      nonempty[v] = wr_ptr[v] != rd_ptr[v];
      full[v] = (wr_ptr[v] - rd_ptr[v]) == (AW+1)'(BUF_DEPTH);
      head[v] = front[v][FLIT_W-2];
      tail[v] = front[v][FLIT_W-1];
      lookup[v] = tbl[front[v][DEST_W-1:0]];
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int v = 0; v < VC_NUM; v++) state[v] <= IDLE;
    end else begin
      for (int v = 0; v < VC_NUM; v++) state[v] <= state_nxt[v];
    end
  end
  always_comb begin
    for (int v = 0; v < VC_NUM; v++)
      state_nxt[v] = (state[v] == IDLE) ? ((nonempty[v] && head[v]) ? FIRST : IDLE) :
                     (state[v] == ROUTE) ? ACTIVE :
                     (pop[v] && tail[v]) ? IDLE : ACTIVE;
  end
  always_comb begin
    for (int v = 0; v < VC_NUM; v++) begin
      eligible[v] = state[v] == ACTIVE && nonempty[v];
      discard[v] = state[v] == IDLE && nonempty[v] && !head[v];
`ifdef NOC_ROUTE_BYPASS_EN
      route_en[v] = state[v] == IDLE && nonempty[v] && head[v];
`else
      route_en[v] = state[v] == ROUTE;
`endif
    end
  end
  // Round-robin: scan from rr_ptr downwards in priority so the lowest offset wins last
  always_comb begin
    logic [VC_W-1:0] idx;
    found = 1'b0;
    gnt = '0;
    for (int i = VC_NUM - 1; i >= 0; i--) begin
      idx = VC_W'((int'(rr_ptr) + i) % VC_NUM);
      if (eligible[idx]) begin
        found = 1'b1;
        gnt = idx;
      end
    end
  end
  assign load = !bus.out_valid || bus.out_ready;
  always_comb begin
    for (int v = 0; v < VC_NUM; v++) begin
      pop[v] = (load && found && int'(gnt) == v) || discard[v];
      push[v] = bus.flit_in_valid && int'(bus.flit_in_vc) == v && (!full[v] || pop[v]);
      drop[v] = bus.flit_in_valid && int'(bus.flit_in_vc) == v && full[v] && !pop[v];
    end
  end
  always_ff @(posedge clk) begin
    for (int v = 0; v < VC_NUM; v++)
      if (push[v]) mem[v][wr_ptr[v][AW-1:0]] <= bus.flit_in;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int v = 0; v < VC_NUM; v++) begin
        wr_ptr[v] <= '0;
        rd_ptr[v] <= '0;
        vc_port[v] <= '0;
      end
      for (int r = 0; r < 2**DEST_W; r++) tbl[r] <= '0;
      rr_ptr <= '0;
      bus.out_valid <= 1'b0;
      bus.flit_out <= '0;
      bus.out_port <= '0;
      bus.out_vc <= '0;
      cred_pend <= 1'b0;
      cred_vc <= '0;
      bus.credit_out_valid <= 1'b0;
      bus.credit_out_vc <= '0;
      err_overflow <= 1'b0;
      err_protocol <= 1'b0;
    end else begin
      for (int v = 0; v < VC_NUM; v++) begin
        wr_ptr[v] <= wr_ptr[v] + (AW+1)'(push[v]);
        rd_ptr[v] <= rd_ptr[v] + (AW+1)'(pop[v]);
        if (route_en[v]) vc_port[v] <= lookup[v];
      end
      if (tbl_we) tbl[tbl_addr] <= tbl_data;
      if (load) bus.out_valid <= found;
      if (load && found) begin
        bus.flit_out <= front[gnt];
        bus.out_port <= vc_port[gnt];
        bus.out_vc <= gnt;
        rr_ptr <= (gnt == VC_W'(VC_NUM - 1)) ? '0 : gnt + 1'b1;
        cred_vc <= gnt;
      end
      // Credit leaves one cycle after the flit is popped into the output register
      cred_pend <= load && found;
      bus.credit_out_valid <= cred_pend;
      bus.credit_out_vc <= cred_vc;
      err_overflow <= err_overflow || (|drop);
      err_protocol <= err_protocol || (|discard);
    end
  end
endmodule

// File: tb/tb_vc_input_unit.sv
// tb_vc_input_unit: scoreboard bench for vc_input_unit (latency, ordering, RR, stall, overflow, protocol, reset)
`timescale 1ns/1ps
module tb_vc_input_unit;
`ifdef NOC_ROUTE_BYPASS_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 4;
`endif
  typedef struct { int cyc; int vc; logic [34:0] d; } obs_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tbl_we = 1'b0;
  logic [3:0] tbl_addr = '0;
  logic [2:0] tbl_data = '0;
  logic err_overflow, err_protocol;
  vc_input_unit_if #(.FLIT_W(32), .VC_NUM(4), .PORT_W(3)) bus();
  vc_input_unit #(.FLIT_W(32), .VC_NUM(4), .BUF_DEPTH(4), .DEST_W(4), .PORT_W(3)) dut (
    .clk(clk), .reset(reset), .bus(bus), .tbl_we(tbl_we), .tbl_addr(tbl_addr),
    .tbl_data(tbl_data), .err_overflow(err_overflow), .err_protocol(err_protocol)
  );
  always #5 clk = ~clk;
  int passed = 0, total = 0, cyc = 0, uid = 1;
  logic [2:0] tbl_m [16];
  logic [2:0] cur_port [4];
  logic [34:0] exp_q [4][$];
  obs_t obs[$];
  int cred [4];
  logic s_ov, s_cv;
  logic [1:0] s_vc, s_cvc;
  logic [2:0] s_port;
  logic [31:0] s_flit;
  task automatic tick();
    @(negedge clk);
    s_ov = bus.out_valid;
    s_cv = bus.credit_out_valid;
    s_vc = bus.out_vc;
    s_cvc = bus.credit_out_vc;
    s_port = bus.out_port;
    s_flit = bus.flit_out;
    if (bus.out_valid && bus.out_ready) obs.push_back('{cyc, int'(bus.out_vc), {bus.out_port, bus.flit_out}});
    if (bus.credit_out_valid) cred[bus.credit_out_vc]++;
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic put(input int vc, input logic [1:0] t, input int d, input bit keep);
    logic [31:0] f;
    f = {t, 26'(uid), 4'(d)};
    uid++;
    if (keep && t[0]) cur_port[vc] = tbl_m[d];
    if (keep) exp_q[vc].push_back({cur_port[vc], f});
    bus.flit_in_valid = 1'b1;
    bus.flit_in = f;
    bus.flit_in_vc = 2'(vc);
    tick();
    bus.flit_in_valid = 1'b0;
  endtask
  task automatic tbl_wr(input int a, input int d);
    tbl_we = 1'b1;
    tbl_addr = 4'(a);
    tbl_data = 3'(d);
    tbl_m[a] = 3'(d);
    tick();
    tbl_we = 1'b0;
  endtask
  function automatic int pending();
    return exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size();
  endfunction
  function automatic int cred_sum();
    return cred[0] + cred[1] + cred[2] + cred[3];
  endfunction
  task automatic test_reset();
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({bus.out_valid, bus.credit_out_valid, err_overflow, err_protocol} !== 4'b0)
      $display("FAIL reset_flags: got %b want 0000", {bus.out_valid, bus.credit_out_valid, err_overflow, err_protocol});
    else passed++;
    total++;
    if ({bus.flit_out, bus.out_port, bus.out_vc, bus.credit_out_vc} !== 39'd0)
      $display("FAIL reset_data: got %h want 0", {bus.flit_out, bus.out_port, bus.out_vc, bus.credit_out_vc});
    else passed++;
    reset = 1'b1;
    tick();
  endtask
  task automatic test_latency(input string tag);
    int n, c0;
    bus.out_ready = 1'b1;
    obs.delete();
    c0 = cred[2];
    put(2, 2'b11, 5, 1);
    n = 0;
    do begin tick(); n++; end while (!s_ov && n < 12);
    total++;
    if (n !== LAT) $display("FAIL %s_out_latency: got %0d want %0d", tag, n, LAT);
    else passed++;
    total++;
    if ({s_vc, s_port} !== {2'd2, 3'd3}) $display("FAIL %s_vc_port: got vc %0d port %0d want vc 2 port 3", tag, s_vc, s_port);
    else passed++;
    while (!s_cv && n < 12) begin tick(); n++; end
    total++;
    if (n !== LAT + 1 || s_cvc !== 2'd2) $display("FAIL %s_credit: got cycle %0d vc %0d want cycle %0d vc 2", tag, n, s_cvc, LAT + 1);
    else passed++;
    repeat (3) tick();
    total++;
    if (obs.size() !== 1 || cred[2] - c0 !== 1) $display("FAIL %s_counts: got %0d flits %0d credits want 1 1", tag, obs.size(), cred[2] - c0);
    else passed++;
    foreach (obs[i]) begin
      logic [34:0] e;
      e = 'x;
      if (exp_q[obs[i].vc].size() > 0) e = exp_q[obs[i].vc].pop_front();
      total++;
      if (obs[i].d !== e) $display("FAIL %s_flit[%0d]: got %h want %h", tag, i, obs[i].d, e);
      else passed++;
    end
  endtask
  task automatic test_packet();
    int c0;
    bus.out_ready = 1'b1;
    obs.delete();
    c0 = cred[0];
    put(0, 2'b01, 2, 1);
    put(0, 2'b00, 0, 1);
    put(0, 2'b00, 0, 1);
    put(0, 2'b10, 0, 1);
    repeat (8) tick();
    total++;
    if (obs.size() !== 4 || obs[3].cyc - obs[0].cyc !== 3)
      $display("FAIL t2_burst: got %0d flits over %0d cycles want 4 over 3", obs.size(), obs.size() == 4 ? obs[3].cyc - obs[0].cyc : -1);
    else passed++;
    total++;
    if (cred[0] - c0 !== 4) $display("FAIL t2_credits: got %0d want 4", cred[0] - c0);
    else passed++;
    put(0, 2'b11, 7, 1);
    repeat (8) tick();
    total++;
    if (obs.size() !== 5) $display("FAIL t2_reuse: got %0d flits want 5", obs.size());
    else passed++;
    foreach (obs[i]) begin
      logic [34:0] e;
      e = 'x;
      if (exp_q[obs[i].vc].size() > 0) e = exp_q[obs[i].vc].pop_front();
      total++;
      if (obs[i].d !== e) $display("FAIL t2_flit[%0d]: got %h want %h", i, obs[i].d, e);
      else passed++;
    end
    total++;
    if (pending() !== 0) $display("FAIL t2_missing: got %0d unemitted want 0", pending());
    else passed++;
  endtask
  task automatic test_interleave_stall();
    logic [36:0] held;
    logic [7:0] seq;
    bus.out_ready = 1'b0;
    obs.delete();
    for (int v = 0; v < 2; v++) begin
      put(v, 2'b01, v ? 9 : 2, 1);
      put(v, 2'b00, 0, 1);
      put(v, 2'b00, 0, 1);
      put(v, 2'b10, 0, 1);
    end
    repeat (4) tick();
    held = {2'd0, exp_q[0][0]};
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if (s_ov !== 1'b1 || {s_vc, s_port, s_flit} !== held)
        $display("FAIL t3_hold[%0d]: got v%b %h want v1 %h", k, s_ov, {s_vc, s_port, s_flit}, held);
      else passed++;
    end
    bus.out_ready = 1'b1;
    repeat (12) tick();
    seq = '0;
    foreach (obs[i]) if (i < 8) seq[i] = obs[i].vc[0];
    total++;
    if (obs.size() !== 8 || seq !== 8'hAA) $display("FAIL t3_alternate: got %0d flits order %b want 8 order 10101010", obs.size(), seq);
    else passed++;
    foreach (obs[i]) begin
      logic [34:0] e;
      e = 'x;
      if (exp_q[obs[i].vc].size() > 0) e = exp_q[obs[i].vc].pop_front();
      total++;
      if (obs[i].d !== e) $display("FAIL t3_flit[%0d]: got %h want %h", i, obs[i].d, e);
      else passed++;
    end
    total++;
    if (pending() !== 0) $display("FAIL t3_missing: got %0d unemitted want 0", pending());
    else passed++;
  endtask
  task automatic test_overflow();
    int n3;
    bus.out_ready = 1'b0;
    obs.delete();
    put(2, 2'b11, 9, 1);
    repeat (4) tick();
    put(3, 2'b01, 2, 1);
    put(3, 2'b00, 0, 1);
    put(3, 2'b00, 0, 1);
    put(3, 2'b10, 0, 1);
    total++;
    if (err_overflow !== 1'b0) $display("FAIL t4_ovf_early: got %b want 0", err_overflow);
    else passed++;
    put(3, 2'b11, 5, 0);
    total++;
    if (err_overflow !== 1'b1) $display("FAIL t4_ovf: got %b want 1", err_overflow);
    else passed++;
    bus.out_ready = 1'b1;
    repeat (12) tick();
    n3 = 0;
    foreach (obs[i]) if (obs[i].vc == 3) n3++;
    total++;
    if (n3 !== 4) $display("FAIL t4_vc3_count: got %0d want 4", n3);
    else passed++;
    foreach (obs[i]) begin
      logic [34:0] e;
      e = 'x;
      if (exp_q[obs[i].vc].size() > 0) e = exp_q[obs[i].vc].pop_front();
      total++;
      if (obs[i].d !== e) $display("FAIL t4_flit[%0d]: got %h want %h", i, obs[i].d, e);
      else passed++;
    end
    total++;
    if (pending() !== 0) $display("FAIL t4_missing: got %0d unemitted want 0", pending());
    else passed++;
  endtask
  task automatic test_protocol();
    int c0;
    bus.out_ready = 1'b1;
    obs.delete();
    c0 = cred_sum();
    total++;
    if (err_protocol !== 1'b0) $display("FAIL t5_prot_early: got %b want 0", err_protocol);
    else passed++;
    put(1, 2'b00, 0, 0);
    repeat (6) tick();
    total++;
    if (err_protocol !== 1'b1) $display("FAIL t5_prot: got %b want 1", err_protocol);
    else passed++;
    total++;
    if (obs.size() !== 0 || cred_sum() - c0 !== 0) $display("FAIL t5_quiet: got %0d flits %0d credits want 0 0", obs.size(), cred_sum() - c0);
    else passed++;
  endtask
  task automatic test_reset_mid();
    int c0;
    bus.out_ready = 1'b0;
    obs.delete();
    put(0, 2'b01, 5, 1);
    put(0, 2'b00, 0, 1);
    put(0, 2'b00, 0, 1);
    repeat (3) tick();
    total++;
    if (s_ov !== 1'b1) $display("FAIL t6_setup: got out_valid %b want 1", s_ov);
    else passed++;
    #3 reset = 1'b0;
    #1;
    total++;
    if ({bus.out_valid, bus.credit_out_valid, err_overflow, err_protocol} !== 4'b0)
      $display("FAIL t6_reset_flags: got %b want 0000", {bus.out_valid, bus.credit_out_valid, err_overflow, err_protocol});
    else passed++;
    total++;
    if ({bus.flit_out, bus.out_port, bus.out_vc, bus.credit_out_vc} !== 39'd0)
      $display("FAIL t6_reset_data: got %h want 0", {bus.flit_out, bus.out_port, bus.out_vc, bus.credit_out_vc});
    else passed++;
    for (int v = 0; v < 4; v++) exp_q[v].delete();
    foreach (tbl_m[i]) tbl_m[i] = '0;
    c0 = cred_sum();
    @(posedge clk);
    #1 reset = 1'b1;
    bus.out_ready = 1'b1;
    repeat (6) tick();
    total++;
    if (obs.size() !== 0 || cred_sum() !== c0) $display("FAIL t6_flushed: got %0d flits %0d credits want 0 0", obs.size(), cred_sum() - c0);
    else passed++;
    tbl_wr(5, 3);
    test_latency("t6");
  endtask
  initial begin
    bus.flit_in_valid = 1'b0;
    bus.flit_in = '0;
    bus.flit_in_vc = '0;
    bus.out_ready = 1'b0;
    foreach (tbl_m[i]) tbl_m[i] = '0;
    foreach (cur_port[i]) cur_port[i] = '0;
    foreach (cred[i]) cred[i] = 0;
    test_reset();
    tbl_wr(5, 3);
    tbl_wr(2, 6);
    tbl_wr(7, 1);
    tbl_wr(9, 5);
    repeat (6) tick();
    test_latency("t1");
    test_packet();
    test_interleave_stall();
    test_overflow();
    test_protocol();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passed, total);
    $fatal(1);
  end
endmodule
